// File: rtl/debug_display_scanner.sv
// Eight-digit seven-segment scanner for the pipeline debug values: left group shows
// LeftValue, right group RightValue. Optional leading-zero blanking: DISP_LZ_BLANK_EN.
module debug_display_scanner #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] LeftValue,
    input  logic [15:0] RightValue,
    output logic [6:0]  out7,
    output logic [7:0]  en_out,
    output logic        FrameTick
);

    localparam int                PrescW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PrescW-1:0] PrescLast = PrescW'(REFRESH_DIV - 1);
    localparam logic [PrescW:0]   GuardLim  = (PrescW + 1)'(GUARD);

    logic [PrescW-1:0] presc;
    logic [2:0]        digit;
    logic [15:0]       shadowL;
    logic [15:0]       shadowR;

    logic        slotEnd;
    logic        frameEnd;
    logic [15:0] groupValue;
    logic [1:0]  nibIdx;
    logic [3:0]  nibble;
    logic        blankDigit;
    logic        inGuard;
    logic [6:0]  segNext;
    logic [7:0]  anodeNext;

    function automatic logic [6:0] hexSeg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        slotEnd    = (presc == PrescLast);
        frameEnd   = slotEnd && (digit == 3'd7);
        groupValue = digit[2] ? shadowL : shadowR;
        nibIdx     = digit[1:0];
        nibble     = groupValue[{nibIdx, 2'b00} +: 4];
`ifdef DISP_LZ_BLANK_EN
        // A digit is dark when it and every higher digit in its group are zero.
        blankDigit = (nibIdx != 2'd0) && ((groupValue >> {nibIdx, 2'b00}) == 16'h0000);
`else
        blankDigit = 1'b0;
`endif
        segNext    = blankDigit ? 7'h7F : hexSeg(nibble);
        inGuard    = ({1'b0, presc} < GuardLim);
        anodeNext  = inGuard ? 8'hFF : ~(8'h01 << digit);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            presc     <= '0;
            digit     <= 3'd0;
            shadowL   <= 16'h0000;
            shadowR   <= 16'h0000;
            out7      <= 7'h7F;
            en_out    <= 8'hFF;
            FrameTick <= 1'b0;
        end else begin
            out7      <= segNext;
            en_out    <= anodeNext;
            FrameTick <= frameEnd;
            if (slotEnd) begin
                presc <= '0;
                digit <= digit + 3'd1;
            end else begin
                presc <= presc + 1'b1;
            end
            // Snapshot once per frame so no digit ever shows a half-updated value.
            if (frameEnd) begin
                shadowL <= LeftValue;
                shadowR <= RightValue;
            end
        end
    end

endmodule
